// File: rtl/pwm_fade_ctrl_if.sv
// CPU-slot and PWM-core-slot signals of the fade controller.
// slave is the controller's view; master is the CPU/PWM side.
interface pwm_fade_ctrl_if;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        pwm_cs;
    logic        pwm_write;
    logic [4:0]  pwm_addr;
    logic [31:0] pwm_wr_data;

    modport slave (
        input  cs, read, write, addr, wr_data,
        output rd_data, pwm_cs, pwm_write, pwm_addr, pwm_wr_data
    );

    modport master (
        output cs, read, write, addr, wr_data,
        input  rd_data, pwm_cs, pwm_write, pwm_addr, pwm_wr_data
    );
endinterface

// File: rtl/pwm_fade_ctrl.sv
// Fade controller: once per step period, moves each PWM channel duty by at most
// STEP toward its CPU-set target and writes the new duty to the PWM core.
module pwm_fade_ctrl #(
    parameter int R = 10,
    parameter int W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    pwm_fade_ctrl_if.slave    bus
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [R:0] DUTY_MAX = {1'b1, {R{1'b0}}};

    typedef enum logic {IDLE, SCAN} state_t;

    state_t        state;
    logic          en;
    logic [31:0]   period;
    logic [31:0]   timer;
    logic [R:0]    step;
    logic [R:0]    tgt [W];
    logic [R:0]    cur [W];
    logic [CW-1:0] ch_idx;

    logic          cpu_wr;
    logic          dvsr_wr;
    logic          en_clear;
    logic          chan_sel;
    logic [CW-1:0] chan;
    logic [R:0]    tgt_wr;
    logic [R+1:0]  cur_x;
    logic [R+1:0]  tgt_x;
    logic [R+1:0]  step_x;
    logic [R+1:0]  nxt;
    logic [W-1:0]  done;
    logic          unused_read;

    assign unused_read = bus.read;

    always_comb begin
        cpu_wr   = bus.cs && bus.write;
        dvsr_wr  = cpu_wr && (bus.addr == 5'h04);
        en_clear = cpu_wr && (bus.addr == 5'h00) && !bus.wr_data[0];
        chan_sel = bus.addr[4] && (int'(bus.addr[3:0]) < W);
        chan     = bus.addr[CW-1:0];
        tgt_wr   = (bus.wr_data[R:0] > DUTY_MAX) ? DUTY_MAX : bus.wr_data[R:0];
    end

    // One extra bit of headroom so cur+STEP and differences never wrap.
    always_comb begin
        cur_x  = {1'b0, cur[ch_idx]};
        tgt_x  = {1'b0, tgt[ch_idx]};
        step_x = {1'b0, step};
        nxt    = cur_x;
        if (cur_x < tgt_x) begin
            nxt = ((tgt_x - cur_x) > step_x) ? (cur_x + step_x) : tgt_x;
        end else if (cur_x > tgt_x) begin
            nxt = ((cur_x - tgt_x) > step_x) ? (cur_x - step_x) : tgt_x;
        end
    end

    always_comb begin
        done = '0;
        for (int i = 0; i < W; i++) begin
            done[i] = (cur[i] == tgt[i]);
        end
    end

    always_comb begin
        bus.rd_data = '0;
        case (bus.addr)
            5'h00:   bus.rd_data = {31'b0, en};
            5'h01:   bus.rd_data = period;
            5'h02:   bus.rd_data = 32'(step);
            5'h03:   bus.rd_data = 32'({done, state == SCAN});
            default: if (chan_sel) bus.rd_data = 32'(cur[chan]);
        endcase
    end

    // A DVSR write owns the PWM bus for its cycle, so the scan stalls in place.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= IDLE;
            en              <= 1'b0;
            period          <= '0;
            step            <= '0;
            timer           <= '0;
            ch_idx          <= '0;
            for (int i = 0; i < W; i++) begin
                tgt[i] <= '0;
                cur[i] <= '0;
            end
            bus.pwm_cs      <= 1'b0;
            bus.pwm_write   <= 1'b0;
            bus.pwm_addr    <= '0;
            bus.pwm_wr_data <= '0;
        end else begin
            bus.pwm_cs    <= 1'b0;
            bus.pwm_write <= 1'b0;

            if (cpu_wr) begin
                case (bus.addr)
                    5'h00: en     <= bus.wr_data[0];
                    5'h01: period <= bus.wr_data;
                    5'h02: step   <= bus.wr_data[R:0];
                    5'h04: begin
                        bus.pwm_cs      <= 1'b1;
                        bus.pwm_write   <= 1'b1;
                        bus.pwm_addr    <= 5'h00;
                        bus.pwm_wr_data <= bus.wr_data;
                    end
                    default: if (chan_sel) tgt[chan] <= tgt_wr;
                endcase
            end

            case (state)
                IDLE: begin
                    if (!en) begin
                        timer <= '0;
                    end else if (timer == period) begin
                        timer  <= '0;
                        ch_idx <= '0;
                        state  <= SCAN;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                SCAN: begin
                    if (!en || en_clear) begin
                        state <= IDLE;
                        timer <= '0;
                    end else if (!dvsr_wr) begin
                        if (nxt != cur_x) begin
                            cur[ch_idx]     <= nxt[R:0];
                            bus.pwm_cs      <= 1'b1;
                            bus.pwm_write   <= 1'b1;
                            bus.pwm_addr    <= {1'b1, 4'(ch_idx)};
                            bus.pwm_wr_data <= 32'(nxt[R:0]);
                        end
                        if (ch_idx == CW'(W - 1)) begin
                            state <= IDLE;
                        end else begin
                            ch_idx <= ch_idx + 1'b1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl: expected PWM writes are queued as stimulus
// is driven and matched in order by a monitor on every PWM strobe.
module tb_pwm_fade_ctrl;
    localparam int R = 10;
    localparam int W = 8;
    localparam logic [4:0] A_CTRL   = 5'h00;
    localparam logic [4:0] A_PERIOD = 5'h01;
    localparam logic [4:0] A_STEP   = 5'h02;
    localparam logic [4:0] A_STATUS = 5'h03;
    localparam logic [4:0] A_DVSR   = 5'h04;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   cycle = 0;
    logic [36:0] exp_q[$];
    int   wr_cyc[$];
    int   base[8] = '{936, 64, 414, 164, 0, 0, 0, 0};

    pwm_fade_ctrl_if bus();

    pwm_fade_ctrl #(.R(R), .W(W)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Every PWM strobe must match the oldest queued expectation.
    always @(negedge clk) begin : monitor
        logic [36:0] e;
        if (bus.pwm_cs === 1'b1) begin
            wr_cyc.push_back(cycle);
            check_output("pwm_write_strobe", 64'(bus.pwm_write), 64'(1));
            check_output("pwm_write_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_output("pwm_write_addr_data", 64'({bus.pwm_addr, bus.pwm_wr_data}), 64'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [4:0] a, input logic [31:0] d);
        bus.cs      = 1'b1;
        bus.write   = 1'b1;
        bus.addr    = a;
        bus.wr_data = d;
        tick();
        bus.cs    = 1'b0;
        bus.write = 1'b0;
    endtask

    task automatic check_read(input logic [4:0] a, input logic [31:0] exp, input string tag);
        bus.addr = a;
        #1;
        check_output(tag, 64'(bus.rd_data), 64'(exp));
    endtask

    task automatic read_status(output logic [31:0] v);
        bus.addr = A_STATUS;
        #1;
        v = bus.rd_data;
    endtask

    task automatic wait_busy(input logic lvl, input string tag);
        int n;
        logic [31:0] s;
        n = 0;
        read_status(s);
        while (s[0] !== lvl && n < 200) begin
            tick();
            n++;
            read_status(s);
        end
        check_output(tag, 64'(s[0]), 64'(lvl));
    endtask

    task automatic wait_drain(input int bound, input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        check_output(tag, 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] s;
        bus.cs = 1'b0;
        bus.read = 1'b0;
        bus.write = 1'b0;
        bus.addr = '0;
        bus.wr_data = '0;

        // Reset state
        repeat (3) tick();
        check_output("reset_pwm_cs", 64'(bus.pwm_cs), 64'(0));
        check_output("reset_pwm_write", 64'(bus.pwm_write), 64'(0));
        check_output("reset_pwm_addr", 64'(bus.pwm_addr), 64'(0));
        check_output("reset_pwm_data", 64'(bus.pwm_wr_data), 64'(0));
        check_read(A_STATUS, 32'h1FE, "reset_status");
        check_read(A_CTRL, 32'h0, "reset_ctrl");
        reset_n = 1'b1;
        tick();

        // Ramp up channel 2 in steps of 100
        apply_stimulus(A_PERIOD, 32'd4);
        apply_stimulus(A_STEP, 32'd100);
        exp_q.push_back({5'h12, 32'd100});
        exp_q.push_back({5'h12, 32'd200});
        exp_q.push_back({5'h12, 32'd300});
        exp_q.push_back({5'h12, 32'd350});
        wr_cyc.delete();
        apply_stimulus(5'h12, 32'd350);
        apply_stimulus(A_CTRL, 32'd1);
        wait_drain(300, "ramp_up_drain");
        check_output("ramp_up_count", 64'(wr_cyc.size()), 64'(4));
        if (wr_cyc.size() >= 4) begin
            for (int i = 1; i < 4; i++) begin
                check_output("ramp_up_spacing", 64'(wr_cyc[i] - wr_cyc[i-1]), 64'(W + 5));
            end
        end
        repeat (40) tick();
        check_read(5'h12, 32'd350, "ramp_up_cur2");
        read_status(s);
        check_output("ramp_up_done2", 64'(s[3]), 64'(1));

        // Saturating target, then a ramp down that lands in one step
        for (int v = 100; v <= 1000; v += 100) exp_q.push_back({5'h10, 32'(v)});
        exp_q.push_back({5'h10, 32'd1024});
        apply_stimulus(5'h10, 32'd2000);
        wait_drain(400, "sat_drain");
        check_read(5'h10, 32'd1024, "sat_cur0");
        exp_q.push_back({5'h10, 32'd1000});
        apply_stimulus(A_STEP, 32'd64);
        apply_stimulus(5'h10, 32'd1000);
        wait_drain(100, "ramp_down_drain");
        repeat (30) tick();
        check_read(5'h10, 32'd1000, "ramp_down_cur0");

        // DVSR write collides with the channel 3 scan slot
        wait_busy(1'b0, "arb_wait_idle");
        apply_stimulus(5'h13, 32'd100);
        wait_busy(1'b1, "arb_wait_scan");
        repeat (3) tick();
        exp_q.push_back({5'h00, 32'h1234});
        exp_q.push_back({5'h13, 32'd64});
        exp_q.push_back({5'h13, 32'd100});
        wr_cyc.delete();
        apply_stimulus(A_DVSR, 32'h1234);
        wait_drain(100, "arb_drain");
        check_output("arb_count", 64'(wr_cyc.size()), 64'(3));
        if (wr_cyc.size() >= 2) begin
            check_output("arb_ch3_follows", 64'(wr_cyc[1] - wr_cyc[0]), 64'(1));
        end
        check_read(5'h13, 32'd100, "arb_cur3");

        // Disable while the scan sits on channel 4
        apply_stimulus(A_CTRL, 32'd0);
        for (int ch = 0; ch < W; ch++) apply_stimulus(5'(16 + ch), 32'd600);
        exp_q.push_back({5'h10, 32'd936});
        exp_q.push_back({5'h11, 32'd64});
        exp_q.push_back({5'h12, 32'd414});
        exp_q.push_back({5'h13, 32'd164});
        apply_stimulus(A_CTRL, 32'd1);
        wait_busy(1'b1, "dis_wait_scan");
        repeat (4) tick();
        apply_stimulus(A_CTRL, 32'd0);
        read_status(s);
        check_output("dis_busy_drop", 64'(s[0]), 64'(0));
        repeat (100) tick();
        check_output("dis_queue_empty", 64'(exp_q.size()), 64'(0));
        check_read(5'h13, 32'd164, "dis_cur3");
        check_read(5'h14, 32'd0, "dis_cur4");

        // STEP=0 freezes every channel
        apply_stimulus(A_STEP, 32'd0);
        wr_cyc.delete();
        apply_stimulus(A_CTRL, 32'd1);
        repeat (50) tick();
        check_output("step0_no_writes", 64'(wr_cyc.size()), 64'(0));
        check_read(5'h10, 32'd936, "step0_cur0");
        apply_stimulus(A_CTRL, 32'd0);
        repeat (3) tick();

        // PERIOD=0, every channel moving: W writes per W+1 cycles
        apply_stimulus(A_PERIOD, 32'd0);
        apply_stimulus(A_STEP, 32'd1);
        for (int ch = 0; ch < W; ch++) apply_stimulus(5'(16 + ch), 32'd1024);
        for (int k = 1; k <= 3; k++) begin
            for (int ch = 0; ch < W; ch++) exp_q.push_back({5'(16 + ch), 32'(base[ch] + k)});
        end
        wr_cyc.delete();
        apply_stimulus(A_CTRL, 32'd1);
        repeat (27) tick();
        apply_stimulus(A_CTRL, 32'd0);
        wait_drain(20, "p0_drain");
        check_output("p0_count", 64'(wr_cyc.size()), 64'(24));
        if (wr_cyc.size() >= 17) begin
            check_output("p0_burst_len", 64'(wr_cyc[7] - wr_cyc[0]), 64'(W - 1));
            check_output("p0_scan1_to_2", 64'(wr_cyc[8] - wr_cyc[0]), 64'(W + 1));
            check_output("p0_scan2_to_3", 64'(wr_cyc[16] - wr_cyc[8]), 64'(W + 1));
        end
        repeat (5) tick();

        // Reset while a ramp is writing
        exp_q.push_back({5'h10, 32'd940});
        apply_stimulus(A_CTRL, 32'd1);
        tick();
        tick();
        check_output("rst_mid_pre_cs", 64'(bus.pwm_cs), 64'(1));
        reset_n = 1'b0;
        tick();
        check_output("rst_mid_cs", 64'(bus.pwm_cs), 64'(0));
        check_read(5'h10, 32'd0, "rst_mid_cur0");
        check_read(A_STATUS, 32'h1FE, "rst_mid_status");
        reset_n = 1'b1;
        tick();
        check_read(A_CTRL, 32'd0, "rst_mid_ctrl");
        repeat (20) tick();
        check_output("final_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
